// File: rtl/pla_eval_pipe.sv
// pla_eval_pipe: run-time programmable sum-of-products (PLA) evaluator.
// N_TERM cubes and per-output polarity are loaded over a config port;
// input vectors stream through a 2-stage valid/ready pipeline.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready, x   input vector handshake (bit i = x_i)
//   out_valid/out_ready, y evaluated outputs handshake
//   cfg_we, cfg_addr,      config write request (held until cfg_ack);
//   cfg_data, cfg_ack      addr < N_TERM = cube slot, addr == N_TERM = inv,
//                          cube data = {osel, care, val}
module pla_eval_pipe #(
    parameter int N_IN   = 6,
    parameter int N_OUT  = 1,
    parameter int N_TERM = 32,
    parameter int AW     = $clog2(N_TERM + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN-1:0]           x,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_OUT-1:0]          y,
    input  logic                      cfg_we,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [N_OUT+2*N_IN-1:0]   cfg_data,
    output logic                      cfg_ack
);

    localparam int DW = N_OUT + 2 * N_IN;
    localparam logic [AW-1:0] POL_ADDR = AW'(N_TERM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT
    } cfg_state_e;

    // Cube table and output polarity
    logic [N_TERM-1:0][N_OUT-1:0] osel_q;
    logic [N_TERM-1:0][N_IN-1:0]  care_q;
    logic [N_TERM-1:0][N_IN-1:0]  val_q;
    logic [N_OUT-1:0]             inv_q;

    // Pipeline state
    logic [N_TERM-1:0] hit_q;
    logic [N_TERM-1:0] hit_d;
    logic              s1_valid_q;
    logic              s1_valid_d;
    logic              s2_valid_q;
    logic [N_OUT-1:0]  y_q;
    logic [N_OUT-1:0]  y_d;
    logic [N_OUT-1:0]  or_acc;

    cfg_state_e state_q;
    cfg_state_e state_d;

    logic accept;
    logic s2_take;
    logic cfg_wr;

    logic [N_IN-1:0]  cfg_val;
    logic [N_IN-1:0]  cfg_care;
    logic [N_OUT-1:0] cfg_osel;

    assign cfg_val  = cfg_data[N_IN-1:0];
    assign cfg_care = cfg_data[2*N_IN-1:N_IN];
    assign cfg_osel = cfg_data[DW-1:2*N_IN];

    // A pending config request blocks new vectors so the table can only
    // change while the pipeline is empty.
    assign s2_take   = ~s2_valid_q | out_ready;
    assign in_ready  = (~s1_valid_q | s2_take) & ~cfg_we & ~rst;
    assign accept    = in_valid & in_ready;
    assign s1_valid_d = accept | (s1_valid_q & ~s2_take);

    assign out_valid = s2_valid_q;
    assign y         = y_q;

    // Stage 1: cube match against the live table
    always_comb begin
        hit_d = '0;
        for (int t = 0; t < N_TERM; t++) begin
            hit_d[t] = (((x ^ val_q[t]) & care_q[t]) == '0)
                       && (osel_q[t] != '0);
        end
    end

    // Stage 2: OR plane plus polarity
    always_comb begin
        or_acc = '0;
        for (int t = 0; t < N_TERM; t++) begin
            if (hit_q[t]) begin
                or_acc = or_acc | osel_q[t];
            end
        end
        y_d = inv_q ^ or_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
        end else begin
            if (accept) begin
                hit_q <= hit_d;
            end
            s1_valid_q <= s1_valid_d;
            if (s2_take) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_q <= y_d;
                end
            end
        end
    end

    // Config FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_ack = 1'b0;
        cfg_wr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!cfg_we) begin
                    state_d = ST_IDLE;
                end else if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // A request withdrawn on the commit cycle is dropped.
                state_d = ST_IDLE;
                cfg_ack = cfg_we;
                cfg_wr  = cfg_we;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Table write; addresses above the polarity slot are acked but ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osel_q <= '0;
            care_q <= '0;
            val_q  <= '0;
            inv_q  <= '0;
        end else if (cfg_wr) begin
            for (int t = 0; t < N_TERM; t++) begin
                if (cfg_addr == AW'(t)) begin
                    osel_q[t] <= cfg_osel;
                    care_q[t] <= cfg_care;
                    val_q[t]  <= cfg_val;
                end
            end
            if (cfg_addr == POL_ADDR) begin
                inv_q <= cfg_data[N_OUT-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pla_eval_pipe.sv
// tb_pla_eval_pipe: table-driven and randomized bench for pla_eval_pipe
// (N_IN=8, N_OUT=3, N_TERM=64) with a queue scoreboard.
module tb_pla_eval_pipe;

    localparam int NI = 8;
    localparam int NO = 3;
    localparam int NT = 64;
    localparam int AW = 7;
    localparam int DW = NO + 2 * NI;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NI-1:0] x;
    logic          out_valid;
    logic          out_ready;
    logic [NO-1:0] y;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_ack;

    pla_eval_pipe #(
        .N_IN  (NI),
        .N_OUT (NO),
        .N_TERM(NT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_ack  (cfg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NI-1:0] xv;
        logic [NO-1:0] yv;
    } vec_t;

    vec_t tbl [22];

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [NO-1:0] sb [$];
    logic [NO-1:0] cur_exp;
    bit            acc_seen;
    bit            ack_seen;
    bit            ov_seen;
    bit            ir_seen;
    logic [NO-1:0] y_seen;
    int            last_cycles;

    logic [NO-1:0] m_osel [NT];
    logic [NI-1:0] m_care [NT];
    logic [NI-1:0] m_val  [NT];
    logic [NO-1:0] m_inv;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        chk_cnt++;
        $display("FAIL %s: timed out, got no response expected one", name);
    endtask

    function automatic logic [NO-1:0] model(input logic [NI-1:0] xv);
        logic [NO-1:0] acc;
        acc = '0;
        for (int t = 0; t < NT; t++) begin
            if ((((xv ^ m_val[t]) & m_care[t]) == '0) && (m_osel[t] != '0))
                acc = acc | m_osel[t];
        end
        return acc ^ m_inv;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < NT; t++) begin
            m_osel[t] = '0;
            m_care[t] = '0;
            m_val[t]  = '0;
        end
        m_inv = '0;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int ia;
        ia = int'(a);
        if (ia < NT) begin
            m_osel[ia] = d[DW-1:2*NI];
            m_care[ia] = d[2*NI-1:NI];
            m_val[ia]  = d[NI-1:0];
        end else if (ia == NT) begin
            m_inv = d[NO-1:0];
        end
    endtask

    function automatic logic [DW-1:0] rnd_cube();
        logic [NI-1:0] c;
        c = ($urandom_range(1) == 0) ? NI'($urandom | $urandom) : NI'($urandom);
        return {NO'($urandom), c, NI'($urandom)};
    endfunction

    // One clock: observe handshakes at the falling edge, return 1 time
    // unit after the next rising edge so the caller can drive inputs.
    task automatic cycle();
        @(negedge clk);
        acc_seen = in_valid && in_ready && !rst;
        ack_seen = cfg_ack;
        ov_seen  = out_valid;
        ir_seen  = in_ready;
        y_seen   = y;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL y_out: got 0x%0h with nothing expected", y);
                end else begin
                    check("y_out", 32'(y), 32'(sb.pop_front()));
                end
            end
            if (acc_seen) sb.push_back(cur_exp);
            if (cfg_ack && cfg_we) model_write(cfg_addr, cfg_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int lo, input int hi);
        int i;
        int g;
        i = lo;
        g = 0;
        while (i <= hi) begin
            if (g >= 100) begin
                fail_timeout("run_vec");
                break;
            end
            in_valid = 1'b1;
            x = tbl[i].xv;
            cur_exp = tbl[i].yv;
            cycle();
            g++;
            if (acc_seen) i++;
        end
        in_valid = 1'b0;
        last_cycles = g;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 || out_valid) begin
            if (g >= 50) begin
                fail_timeout("drain");
                break;
            end
            cycle();
            g++;
        end
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int n);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        n = 0;
        forever begin
            cycle();
            if (ack_seen) break;
            n++;
            if (n > 100) begin
                fail_timeout("cfg_ack");
                break;
            end
        end
        cfg_we = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  i;
        int  nacc;
        int  cyc;
        bit  abort_plan;
        bit  a0;
        bit  a1;
        bit  a2;

        tbl[0]  = '{8'hFF, 3'b000};
        tbl[1]  = '{8'h03, 3'b001};
        tbl[2]  = '{8'h01, 3'b000};
        tbl[3]  = '{8'h3F, 3'b001};
        tbl[4]  = '{8'h03, 3'b000};
        tbl[5]  = '{8'h00, 3'b001};
        tbl[6]  = '{8'h03, 3'b000};
        tbl[7]  = '{8'h00, 3'b001};
        tbl[8]  = '{8'h07, 3'b000};
        tbl[9]  = '{8'h02, 3'b001};
        tbl[10] = '{8'h01, 3'b001};
        tbl[11] = '{8'h03, 3'b000};
        tbl[12] = '{8'h03, 3'b001};
        tbl[13] = '{8'h03, 3'b001};
        tbl[14] = '{8'h00, 3'b000};
        tbl[15] = '{8'h83, 3'b001};
        tbl[16] = '{8'h80, 3'b110};
        tbl[17] = '{8'h83, 3'b111};
        tbl[18] = '{8'h01, 3'b000};
        tbl[19] = '{8'hFF, 3'b111};
        tbl[20] = '{8'hFF, 3'b111};
        tbl[21] = '{8'hFF, 3'b000};

        rst = 1'b1;
        in_valid = 1'b0;
        x = '0;
        out_ready = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        cur_exp = '0;
        model_clear();

        // Reset state
        cycle();
        cycle();
        check("rst_out_valid", 32'(ov_seen), 0);
        check("rst_y", 32'(y_seen), 0);
        check("rst_cfg_ack", 32'(ack_seen), 0);
        rst = 1'b0;
        cycle();
        check("in_ready_after_rst", 32'(ir_seen), 1);

        // Empty table
        run_vec(0, 0);
        drain();

        // Slot 0 = x0 & x1, pipeline empty -> ack two cycles after request
        cfg_write(7'd0, {3'b001, 8'h03, 8'h03}, n);
        check("ack_empty_latency", n, 2);
        run_vec(1, 3);
        check("stream_throughput", last_cycles, 3);
        drain();

        // Polarity inv=1, then 2-cycle latency by hand
        cfg_write(7'(NT), 19'd1, n);
        in_valid = 1'b1;
        x = tbl[4].xv;
        cur_exp = tbl[4].yv;
        cycle();
        check("lat_accept", 32'(acc_seen), 1);
        in_valid = 1'b0;
        cycle();
        check("lat_after_k", 32'(ov_seen), 0);
        cycle();
        check("lat_after_k1", 32'(ov_seen), 1);
        run_vec(5, 5);
        drain();

        // Backpressure: 5 stalled cycles, only 2 vectors fit
        out_ready = 1'b0;
        i = 6;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            x = tbl[i].xv;
            cur_exp = tbl[i].yv;
            cycle();
            if (acc_seen) i++;
        end
        check("bp_accepted", i - 6, 2);
        check("bp_in_ready", 32'(ir_seen), 0);
        out_ready = 1'b1;
        run_vec(i, 9);
        drain();
        check("bp_no_dup", sb.size(), 0);

        // Config request with two vectors in flight; a vector waits on it
        run_vec(10, 11);
        in_valid = 1'b1;
        x = tbl[12].xv;
        cur_exp = tbl[12].yv;
        cfg_write(7'(NT), 19'd0, n);
        check("ack_inflight_latency", n, 3);
        cycle();
        check("ack_one_cycle", 32'(ack_seen), 0);
        check("vec_after_cfg", 32'(acc_seen), 1);
        in_valid = 1'b0;
        drain();

        // Abort: request withdrawn before ack, slot 0 untouched
        cfg_we = 1'b1;
        cfg_addr = 7'd0;
        cfg_data = '0;
        cycle();
        a0 = ack_seen;
        cfg_we = 1'b0;
        cycle();
        a1 = ack_seen;
        cycle();
        a2 = ack_seen;
        check("abort_no_ack", 32'(a0 | a1 | a2), 0);
        run_vec(13, 13);
        drain();

        // Out-of-range address: acked, no effect
        cfg_write(7'd100, '1, n);
        check("ack_oor_latency", n, 2);
        run_vec(14, 15);
        drain();

        // Multi-output cube on x7
        cfg_write(7'd5, {3'b110, 8'h80, 8'h80}, n);
        run_vec(16, 18);
        drain();

        // Reset with two vectors in flight
        out_ready = 1'b0;
        run_vec(19, 20);
        rst = 1'b1;
        cycle();
        check("midrst_out_valid", 32'(ov_seen), 0);
        check("midrst_y", 32'(y_seen), 0);
        check("midrst_cfg_ack", 32'(ack_seen), 0);
        rst = 1'b0;
        model_clear();
        out_ready = 1'b1;
        run_vec(21, 21);
        drain();

        // Random tables, random backpressure and config traffic
        for (int k = 0; k < 40; k++)
            cfg_write(7'($urandom_range(NT - 1)), rnd_cube(), n);
        cfg_write(7'(NT), 19'($urandom_range(7)), n);
        nacc = 0;
        cyc = 0;
        abort_plan = 1'b0;
        in_valid = 1'b0;
        while (nacc < 10000) begin
            if (cyc >= 60000) begin
                fail_timeout("random_run");
                break;
            end
            out_ready = ($urandom_range(3) != 0);
            if (!in_valid) begin
                in_valid = ($urandom_range(3) != 0);
                x = NI'($urandom);
            end
            if (!cfg_we) begin
                if ($urandom_range(149) == 0) begin
                    cfg_we = 1'b1;
                    cfg_addr = 7'($urandom_range(NT + 6));
                    cfg_data = rnd_cube();
                    abort_plan = ($urandom_range(5) == 0);
                end
            end else if (abort_plan && $urandom_range(2) == 0) begin
                cfg_we = 1'b0;
            end
            cur_exp = model(x);
            cycle();
            cyc++;
            if (acc_seen) begin
                nacc++;
                in_valid = 1'b0;
            end
            if (ack_seen) cfg_we = 1'b0;
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        out_ready = 1'b1;
        drain();
        check("random_vectors", nacc, 10000);
        check("random_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
